ws2812_bit_encoder: RTL and testbench

Converts a stream of colour bits into the WS2812 single-wire waveform and generates the reset/latch low period that ends a frame. Sits directly downstream of the 24-bit colour serializer: each accepted bit becomes one high-then-low pulse of fixed period, and a latch request produces a long low interval. Its `dout` output drives the LED strip data pin.

---
 rtl/ws2812_bit_encoder.sv | 143 ++++++++++++++
 tb/tb_ws2812_bit_encoder.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/ws2812_bit_encoder.sv
// ws2812_bit_encoder
//
// Turns a valid/ready stream of colour bits into the WS2812 single-wire
// waveform. Each accepted bit becomes one high-then-low pulse of BIT_CYC
// clocks. The high time is T1H_CYC for a '1' and T0H_CYC for a '0'. A latch
// request at a bit boundary produces a RST_CYC-long low interval that ends
// the frame.
//
// Ports
//   clk        system clock, rising edge
//   rstn       asynchronous active-low reset
//   bit_valid  bit_in is offered (held with bit_in until bit_ready)
//   bit_in     colour bit to encode
//   bit_ready  combinational; high only at an accept point
//   latch_req  level request for a latch period
//   latch_done one-cycle pulse in the first IDLE cycle after a latch
//   busy       registered; low only in IDLE
//   dout       registered WS2812 data line
//
// State table
//   state   | meaning
//   S_IDLE  | line low, waiting for a bit or a latch request
//   S_HIGH  | high phase of a bit, cnt counts from bit start
//   S_LOW   | low phase of a bit, last cycle (cnt = BIT_CYC-1) accepts
//   S_LATCH | latch low interval, cnt counts 0 .. RST_CYC-1
module ws2812_bit_encoder #(
  parameter int T0H_CYC = 20,
  parameter int T1H_CYC = 40,
  parameter int BIT_CYC = 63,
  parameter int RST_CYC = 4000,
  parameter int CNT_W   = 16
) (
  input  logic clk,
  input  logic rstn,
  input  logic bit_valid,
  input  logic bit_in,
  output logic bit_ready,
  input  logic latch_req,
  output logic latch_done,
  output logic busy,
  output logic dout
);

  if (!(CNT_W >= 1 && CNT_W <= 32 &&
        T0H_CYC > 0 && T0H_CYC < T1H_CYC && T1H_CYC < BIT_CYC &&
        RST_CYC >= 1 &&
        longint'(BIT_CYC) < (longint'(1) << CNT_W) &&
        longint'(RST_CYC) < (longint'(1) << CNT_W))) begin : g_param_check
    $error("ws2812_bit_encoder: illegal timing parameters");
  end

  localparam logic [CNT_W-1:0] T0H_LAST = CNT_W'(T0H_CYC - 1);
  localparam logic [CNT_W-1:0] T1H_LAST = CNT_W'(T1H_CYC - 1);
  localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(BIT_CYC - 1);
  localparam logic [CNT_W-1:0] RST_LAST = CNT_W'(RST_CYC - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_HIGH  = 2'd1,
    S_LOW   = 2'd2,
    S_LATCH = 2'd3
  } state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             th_sel, th_sel_nxt;
  logic             done_nxt;
  logic [CNT_W-1:0] th_last;

  assign th_last = th_sel ? T1H_LAST : T0H_LAST;

  // Accept point: idle, or the final low cycle of a bit, so a streamed bit
  // starts its high phase on the very next edge with no gap.
  always_comb begin
    bit_ready = (state == S_IDLE) || ((state == S_LOW) && (cnt == BIT_LAST));
  end

  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt + 1'b1;
    th_sel_nxt = th_sel;
    done_nxt   = 1'b0;

    case (state)
      S_IDLE: begin
        cnt_nxt = '0;
      end
      S_HIGH: begin
        if (cnt == th_last) begin
          state_nxt = S_LOW;
        end
      end
      S_LOW: begin
        // leaving LOW only happens at the accept point, handled below
      end
      S_LATCH: begin
        if (cnt == RST_LAST) begin
          state_nxt = S_IDLE;
          cnt_nxt   = '0;
          done_nxt  = 1'b1;
        end
      end
      default: begin
        state_nxt = S_IDLE;
        cnt_nxt   = '0;
      end
    endcase

    // Priority at an accept point: bit, then latch, then idle.
    if (bit_ready) begin
      cnt_nxt = '0;
      if (bit_valid) begin
        state_nxt  = S_HIGH;
        th_sel_nxt = bit_in;
      end else if (latch_req) begin
        state_nxt = S_LATCH;
      end else begin
        state_nxt = S_IDLE;
      end
    end
  end

  // dout and busy are registered from the next state so the line rises on
  // the edge right after the accept.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state      <= S_IDLE;
      cnt        <= '0;
      th_sel     <= 1'b0;
      latch_done <= 1'b0;
      dout       <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      th_sel     <= th_sel_nxt;
      latch_done <= done_nxt;
      dout       <= (state_nxt == S_HIGH);
      busy       <= (state_nxt != S_IDLE);
    end
  end

endmodule

// File: tb/tb_ws2812_bit_encoder.sv
// Testbench for ws2812_bit_encoder with short timing parameters.
// A timeline reference model predicts every output in every cycle from the
// bit/latch schedule: a bit accepted in cycle s owns cycles s+1..s+BIT and is
// high for the first TH of them; a latch decided in cycle s owns s+1..s+RST.
module tb_ws2812_bit_encoder;

  localparam int T0H = 2;
  localparam int T1H = 4;
  localparam int BIT = 6;
  localparam int RST = 10;

  logic clk = 1'b0;
  logic rstn;
  logic bit_valid;
  logic bit_in;
  logic bit_ready;
  logic latch_req;
  logic latch_done;
  logic busy;
  logic dout;

  ws2812_bit_encoder #(
    .T0H_CYC(T0H),
    .T1H_CYC(T1H),
    .BIT_CYC(BIT),
    .RST_CYC(RST),
    .CNT_W  (8)
  ) dut (
    .clk       (clk),
    .rstn      (rstn),
    .bit_valid (bit_valid),
    .bit_in    (bit_in),
    .bit_ready (bit_ready),
    .latch_req (latch_req),
    .latch_done(latch_done),
    .busy      (busy),
    .dout      (dout)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // model: kind 0 = idle, 1 = bit in flight, 2 = latch in progress
  int m_kind = 0;
  int m_off  = 0;
  int m_th   = 0;
  bit m_done = 1'b0;

  bit q[$];        // bits waiting to be sent, front is offered
  int lreq_mode = 0; // 0 off, 1 held, 2 held until latch_done

  task automatic chk(input string tag, input logic obs, input logic exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s at cycle %0d: observed %b, expected %b", tag, cyc, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_kind = 0;
    m_off  = 0;
    m_th   = 0;
    m_done = 1'b0;
  endtask

  task automatic run_cycle();
    logic e_dout, e_ready, e_busy, e_done;
    bit   acc;
    e_dout  = 1'b0;
    e_ready = 1'b0;
    e_busy  = 1'b1;
    e_done  = 1'b0;
    case (m_kind)
      0: begin
        e_ready = 1'b1;
        e_busy  = 1'b0;
        e_done  = m_done;
      end
      1: begin
        e_dout  = (m_off <= m_th);
        e_ready = (m_off == BIT);
      end
      default: ;
    endcase

    if (lreq_mode == 2 && m_done) lreq_mode = 0;
    latch_req = (lreq_mode != 0);
    bit_valid = (q.size() > 0);
    bit_in    = bit_valid ? q[0] : 1'b0;

    @(negedge clk);
    chk("dout", dout, e_dout);
    chk("bit_ready", bit_ready, e_ready);
    chk("busy", busy, e_busy);
    chk("latch_done", latch_done, e_done);

    acc = (m_kind == 0) || (m_kind == 1 && m_off == BIT);
    if (acc) begin
      m_done = 1'b0;
      if (bit_valid) begin
        m_kind = 1;
        m_off  = 1;
        m_th   = bit_in ? T1H : T0H;
        void'(q.pop_front());
      end else if (latch_req) begin
        m_kind = 2;
        m_off  = 1;
      end else begin
        m_kind = 0;
      end
    end else if (m_kind == 2 && m_off == RST) begin
      m_kind = 0;
      m_done = 1'b1;
    end else begin
      m_off++;
    end

    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) run_cycle();
  endtask

  // Asynchronous reset applied in the middle of a cycle.
  task automatic async_reset();
    rstn = 1'b0;
    #2;
    chk("rst_dout", dout, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_latch_done", latch_done, 1'b0);
    chk("rst_bit_ready", bit_ready, 1'b1);
    model_reset();
    q.delete();
    lreq_mode = 0;
    bit_valid = 1'b0;
    bit_in    = 1'b0;
    latch_req = 1'b0;
    @(posedge clk);
    #1;
    rstn = 1'b1;
  endtask

  initial begin
    logic [23:0] pattern;
    rstn      = 1'b0;
    bit_valid = 1'b0;
    bit_in    = 1'b0;
    latch_req = 1'b0;
    #12;
    chk("init_dout", dout, 1'b0);
    chk("init_busy", busy, 1'b0);
    chk("init_latch_done", latch_done, 1'b0);
    chk("init_bit_ready", bit_ready, 1'b1);
    @(posedge clk);
    #1;
    rstn = 1'b1;
    model_reset();

    // single '1' from idle
    q.push_back(1'b1);
    run(9);

    // 24-bit back-to-back stream, MSB first
    pattern = 24'hA5F00F;
    for (int i = 23; i >= 0; i--) q.push_back(pattern[i]);
    run(24 * BIT + 4);

    // bit and latch request together: bit first, then latch
    q.push_back(1'b0);
    lreq_mode = 2;
    run(BIT + RST + 5);

    // latch request held: latches repeat until it drops
    lreq_mode = 1;
    run(2 * (RST + 1) + 3);
    lreq_mode = 0;
    run(RST + 4);

    // reset in the middle of the high phase of a '1'
    q.push_back(1'b1);
    run(2);
    async_reset();
    q.push_back(1'b0);
    run(BIT + 3);

    // bit offered during a latch is held until the done cycle
    lreq_mode = 2;
    run(3);
    q.push_back(1'b1);
    run(RST + BIT + 4);

    // randomized traffic: sparse and bursty bits mixed with latch requests
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 2) == 0 && q.size() < 4) q.push_back(1'($urandom_range(0, 1)));
      if (lreq_mode == 0 && $urandom_range(0, 50) == 0) lreq_mode = 2;
      run_cycle();
    end

    // one random reset during traffic, then drain
    q.push_back(1'b1);
    q.push_back(1'b0);
    run($urandom_range(1, 8));
    async_reset();
    q.push_back(1'($urandom_range(0, 1)));
    run(2 * BIT);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
